// File: rtl/decoder_proj_pkg.sv
// Shared definitions for the decoder_proj front end: FSM encoding, default
// code width and the debounce counter sizing helper.
package decoder_proj_pkg;

    localparam int WIDTH_DEFAULT = 7;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        SETTLE = 2'd1,
        TRACK  = 2'd2
    } cond_state_t;

    function automatic int counter_width(input int debounce_cycles);
        return $clog2(debounce_cycles);
    endfunction

endpackage

// File: rtl/decoder_input_conditioner_if.sv
// Pad-side and decoder-side signals of the input conditioner. The master
// drives the raw pads and enable; the slave (the conditioner) drives the code.
interface decoder_input_conditioner_if
    import decoder_proj_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int GLITCH_W = 8
);
    logic [WIDTH-1:0]    io_in;
    logic                enable;
    logic [WIDTH-1:0]    code_out;
    logic                code_valid;
    logic                stable;
    logic [GLITCH_W-1:0] glitch_count;

    modport master (
        output io_in, enable,
        input  code_out, code_valid, stable, glitch_count
    );

    modport slave (
        input  io_in, enable,
        output code_out, code_valid, stable, glitch_count
    );
endinterface

// File: rtl/decoder_input_conditioner_pad_sync.sv
// WIDTH x STAGES plain flop synchroniser for asynchronous pad inputs.
// Nothing sits between stages so metastability gets full cycles to resolve.
module pad_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] q_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clock or posedge reset) begin
                if (reset) q_reg <= '0;
                else       q_reg <= d;
            end
        end else begin : g_next
            always_ff @(posedge clock or posedge reset) begin
                if (reset) q_reg <= '0;
                else       q_reg <= g_stage[gi-1].q_reg;
            end
        end
    end

    assign q = g_stage[STAGES-1].q_reg;
endmodule

// File: rtl/decoder_input_conditioner.sv
// Synchronises the raw pad word, debounces it as a unit and publishes each
// new stable code with a one-cycle strobe; abandoned candidates are counted.
module decoder_input_conditioner
    import decoder_proj_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_W        = 8
) (
    input logic                        clock,
    input logic                        reset,
    decoder_input_conditioner_if.slave bus
);
    localparam int             CW       = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]    sync_q;
    cond_state_t         state_reg, state_next;
    logic [WIDTH-1:0]    candidate_reg, candidate_next;
    logic [CW-1:0]       counter_reg, counter_next;
    logic [WIDTH-1:0]    code_reg, code_next;
    logic                valid_reg, valid_next;
    logic                stable_reg, stable_next;
    logic [GLITCH_W-1:0] glitch_reg, glitch_next;
    logic                accepted_reg, accepted_next;

    pad_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_pad_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.io_in),
        .q     (sync_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= INIT;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.enable) begin
            unique case (state_reg)
                INIT:    state_next = SETTLE;
                SETTLE:  if (sync_q == candidate_reg && counter_reg == CNT_LAST)
                             state_next = TRACK;
                TRACK:   if (sync_q != code_reg) state_next = SETTLE;
                default: state_next = INIT;
            endcase
        end
    end

    always_comb begin
        candidate_next = candidate_reg;
        counter_next   = counter_reg;
        code_next      = code_reg;
        valid_next     = 1'b0;
        stable_next    = stable_reg;
        glitch_next    = glitch_reg;
        accepted_next  = accepted_reg;
        if (bus.enable) begin
            unique case (state_reg)
                INIT: begin
                    candidate_next = sync_q;
                    counter_next   = '0;
                    stable_next    = 1'b0;
                end
                SETTLE: begin
                    stable_next = 1'b0;
                    if (sync_q != candidate_reg) begin
                        candidate_next = sync_q;
                        counter_next   = '0;
                        // Before the first acceptance the synchroniser is still
                        // filling from its reset value, so that is not a glitch.
                        if (accepted_reg && glitch_reg != '1)
                            glitch_next = glitch_reg + GLITCH_W'(1);
                    end else if (counter_reg == CNT_LAST) begin
                        code_next     = candidate_reg;
                        valid_next    = !accepted_reg || (candidate_reg != code_reg);
                        accepted_next = 1'b1;
                    end else begin
                        counter_next = counter_reg + CW'(1);
                    end
                end
                TRACK: begin
                    if (sync_q != code_reg) begin
                        candidate_next = sync_q;
                        counter_next   = '0;
                        stable_next    = 1'b0;
                    end else begin
                        stable_next = 1'b1;
                    end
                end
                default: begin
                    stable_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            candidate_reg <= '0;
            counter_reg   <= '0;
            code_reg      <= '0;
            valid_reg     <= 1'b0;
            stable_reg    <= 1'b0;
            glitch_reg    <= '0;
            accepted_reg  <= 1'b0;
        end else begin
            candidate_reg <= candidate_next;
            counter_reg   <= counter_next;
            code_reg      <= code_next;
            valid_reg     <= valid_next;
            stable_reg    <= stable_next;
            glitch_reg    <= glitch_next;
            accepted_reg  <= accepted_next;
        end
    end

    assign bus.code_out     = code_reg;
    assign bus.code_valid   = valid_reg;
    assign bus.stable       = stable_reg;
    assign bus.glitch_count = glitch_reg;
endmodule

// File: tb/tb_decoder_input_conditioner.sv
// Randomised and directed bench for decoder_input_conditioner with a
// run-length reference model and a published-code scoreboard.
module tb_decoder_input_conditioner;
    localparam int W = 7;
    localparam int S = 2;
    localparam int D = 4;
    localparam int G = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    decoder_input_conditioner_if #(.WIDTH(W), .GLITCH_W(G)) bus ();

    decoder_input_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .GLITCH_W        (G)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a code is published once the synchronised word has been
    // seen unchanged on D+1 consecutive enabled edges; the pad delay is S edges.
    logic [W-1:0] m_pipe [S];
    bit           m_first;
    logic [W-1:0] m_run_val;
    int           m_run_len;
    bit           m_pub;
    logic [W-1:0] m_code;
    bit           m_valid;
    bit           m_stable;
    int           m_glitch;
    logic [W-1:0] exp_q [$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < S; i++) m_pipe[i] = '0;
            m_first = 1'b1; m_run_val = '0; m_run_len = 0; m_pub = 1'b0;
            m_code = '0; m_valid = 1'b0; m_stable = 1'b0; m_glitch = 0;
            exp_q.delete();
        end else begin
            logic [W-1:0] s;
            s = m_pipe[S-1];
            for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = bus.io_in;
            m_valid = 1'b0;
            if (bus.enable) begin
                if (m_first) begin
                    m_first = 1'b0; m_run_val = s; m_run_len = 1; m_stable = 1'b0;
                end else if (s != m_run_val) begin
                    if (m_run_len < D + 1 && m_pub && m_glitch < (1 << G) - 1) m_glitch++;
                    m_run_val = s; m_run_len = 1; m_stable = 1'b0;
                end else begin
                    if (m_run_len < D + 2) m_run_len++;
                    if (m_run_len == D + 1) begin
                        m_valid = !m_pub || (m_run_val != m_code);
                        if (m_valid) exp_q.push_back(m_run_val);
                        m_code = m_run_val; m_pub = 1'b1; m_stable = 1'b0;
                    end else begin
                        m_stable = (m_run_len == D + 2);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        check("code_valid", int'(bus.code_valid), int'(m_valid));
        check("code_out", int'(bus.code_out), int'(m_code));
        check("stable", int'(bus.stable), int'(m_stable));
        check("glitch_count", int'(bus.glitch_count), m_glitch);
        if (bus.code_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(bus.code_out), -1);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("published_code", int'(bus.code_out), int'(e));
                $display("pulse code=%02h expected=%02h t=%0t", bus.code_out, e, $time);
            end
        end
    end

    task automatic drive(input logic [W-1:0] v, input int n);
        @(negedge clock); #1;
        bus.io_in = v;
        repeat (n) @(posedge clock);
    endtask

    // Releases reset with v on the pads; returns edges from E0 to the strobe.
    task automatic release_and_time(input logic [W-1:0] v, output int lat);
        @(negedge clock); #1;
        reset = 1'b0;
        bus.io_in = v;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clock); #1;
            if (bus.code_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int p0;
        logic [W-1:0] v;
        reset = 1'b1;
        bus.io_in = '0;
        bus.enable = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_code_out", int'(bus.code_out), 0);
        check("rst_glitch", int'(bus.glitch_count), 0);

        // First publication through INIT
        release_and_time(7'h44, lat);
        check("init_latency", lat, 6);
        check("init_code", int'(bus.code_out), 'h44);
        @(posedge clock); #1;
        check("init_stable", int'(bus.stable), 1);
        check("init_glitch", int'(bus.glitch_count), 0);

        // Short excursion that reverts
        p0 = pulses;
        drive(7'h45, 2);
        drive(7'h44, 10);
        check("revert_code", int'(bus.code_out), 'h44);
        check("revert_glitch", int'(bus.glitch_count), 1);
        check("revert_pulses", pulses - p0, 0);

        // Clean change
        p0 = pulses;
        drive(7'h7F, 12);
        check("change_code", int'(bus.code_out), 'h7F);
        check("change_pulses", pulses - p0, 1);

        // Frozen while disabled, resumes on enable
        p0 = pulses;
        @(negedge clock); #1;
        bus.enable = 1'b0;
        bus.io_in = 7'h01;
        repeat (10) @(posedge clock);
        #1;
        check("frozen_code", int'(bus.code_out), 'h7F);
        check("frozen_pulses", pulses - p0, 0);
        @(negedge clock); #1;
        bus.enable = 1'b1;
        repeat (D) @(posedge clock);
        #1;
        check("reenable_early", int'(bus.code_out), 'h7F);
        @(posedge clock); #1;
        check("reenable_code", int'(bus.code_out), 'h01);

        // Randomised pads and enable
        for (int n = 0; n < 120; n++) begin
            @(negedge clock); #1;
            bus.enable = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 2))
                0:       v = W'($urandom_range(0, 127));
                1:       v = bus.io_in ^ W'(1 << $urandom_range(0, W - 1));
                default: v = bus.io_in;
            endcase
            bus.io_in = v;
            repeat ($urandom_range(1, 8)) @(posedge clock);
        end
        @(negedge clock); #1;
        bus.enable = 1'b1;

        // Reset in the middle of a settle
        drive(7'h22, S + 2);
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        check("midrst_code", int'(bus.code_out), 0);
        check("midrst_valid", int'(bus.code_valid), 0);
        check("midrst_stable", int'(bus.stable), 0);
        check("midrst_glitch", int'(bus.glitch_count), 0);
        repeat (2) @(posedge clock);
        release_and_time(7'h22, lat);
        check("reinit_latency", lat, 6);
        check("reinit_code", int'(bus.code_out), 'h22);
        repeat (3) @(posedge clock);

        // Toggle bit 0 every cycle to saturate the glitch counter
        p0 = pulses;
        for (int n = 0; n < 300; n++) drive(bus.io_in ^ 7'h01, 1);
        #1;
        check("sat_glitch", int'(bus.glitch_count), 'hFF);
        check("sat_pulses", pulses - p0, 0);
        check("sat_code", int'(bus.code_out), 'h22);

        drive(7'h22, 20);
        @(negedge clock); #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
